// File: rtl/chip8_pkg.sv
// Shared Chip-8 framebuffer definitions.
//   cpu_op_e   : CPU framebuffer operation encodings
//   fb_state_e : framebuffer arbiter FSM states
//   FB_BYTES / FB_ROW_BYTES / FB_ADDR_W : 64x32 1-bpp framebuffer geometry
package chip8_pkg;

  localparam int unsigned FB_BYTES     = 256;
  localparam int unsigned FB_ROW_BYTES = 8;
  localparam int unsigned FB_ADDR_W    = $clog2(FB_BYTES);

  typedef enum logic [1:0] {
    OP_DRAW  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } cpu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RDW,
    ST_WR,
    ST_CLR,
    ST_ACK
  } fb_state_e;

endpackage

// File: rtl/fb_ram.sv
// 256x8 single-port synchronous RAM, one access per cycle, read-first,
// one-cycle read latency. Written to infer block RAM.
//   clk   : clock
//   en    : access enable
//   we    : write enable (qualified by en)
//   addr  : byte address
//   wdata : write data
//   rdata : registered read data (old contents on a write)
module fb_ram
  import chip8_pkg::*;
(
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [FB_ADDR_W-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  logic [7:0] mem [FB_BYTES];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Chip-8 framebuffer arbiter: shares one single-port RAM between a VGA
// fetcher (strict priority, always accepted) and the Chip-8 core
// (read, XOR-draw with collision, clear-all). Optional clear after reset.
//   clk, rst                : clock, synchronous active-high reset
//   vga_req/addr            : VGA byte fetch
//   vga_rdata/rvalid        : VGA read data, valid one cycle after vga_req
//   cpu_req/op/addr/wdata   : CPU request, held until cpu_ack
//   cpu_ack                 : one-cycle completion pulse
//   cpu_rdata/cpu_collision : pre-operation byte / draw collision, held
//   ready                   : low while the post-reset clear runs
module fb_arbiter
  import chip8_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vga_req,
  input  logic [7:0] vga_addr,
  output logic [7:0] vga_rdata,
  output logic       vga_rvalid,
  input  logic       cpu_req,
  input  logic [1:0] cpu_op,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  output logic       cpu_collision,
  output logic       ready
);

  localparam logic [FB_ADDR_W-1:0] CLR_LAST = FB_ADDR_W'(FB_BYTES - 1);

  fb_state_e state, next_state;
  cpu_op_e   op;

  logic                 init_busy;
  logic [FB_ADDR_W-1:0] clr_cnt;
  logic                 clr_adv;
  logic [7:0]           old_q;
  logic [7:0]           rdata_q;
  logic                 coll_q;
  logic                 rvalid_q;

  logic                 ram_en;
  logic                 ram_we;
  logic [FB_ADDR_W-1:0] ram_addr;
  logic [7:0]           ram_wdata;
  logic [7:0]           ram_rdata;

  assign op = cpu_op_e'(cpu_op);

  fb_ram u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Next state and RAM port mux. VGA owns the port in any cycle it requests;
  // the FSM only touches RAM in cycles with vga_req low.
  always_comb begin
    next_state = state;
    ram_en     = vga_req;
    ram_we     = 1'b0;
    ram_addr   = vga_addr;
    ram_wdata  = '0;
    clr_adv    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_busy) begin
          next_state = ST_CLR;
        end else if (cpu_req) begin
          if (op == OP_CLEAR) begin
            next_state = ST_CLR;
          end else if (!vga_req) begin
            ram_en     = 1'b1;
            ram_addr   = cpu_addr;
            next_state = ST_RDW;
          end
        end
      end
      ST_RDW: begin
        next_state = (op == OP_DRAW) ? ST_WR : ST_ACK;
      end
      ST_WR: begin
        if (!vga_req) begin
          ram_en     = 1'b1;
          ram_we     = 1'b1;
          ram_addr   = cpu_addr;
          ram_wdata  = old_q ^ cpu_wdata;
          next_state = ST_ACK;
        end
      end
      ST_CLR: begin
        if (!vga_req) begin
          ram_en   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = clr_cnt;
          clr_adv  = 1'b1;
          if (clr_cnt == CLR_LAST) begin
            next_state = init_busy ? ST_IDLE : ST_ACK;
          end
        end
      end
      ST_ACK: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    // A reset arriving mid-operation must not let the pending write land.
    if (rst) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_busy <= CLEAR_ON_RESET;
      clr_cnt   <= '0;
      old_q     <= '0;
      rdata_q   <= '0;
      coll_q    <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= vga_req;
      if (state == ST_RDW) begin
        old_q <= ram_rdata;
      end
      if (clr_adv) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
      if (state == ST_CLR && next_state == ST_IDLE) begin
        init_busy <= 1'b0;
      end
      // Result registers change only on entry to ACK so they stay stable
      // between acknowledgements.
      if (next_state == ST_ACK && state != ST_ACK) begin
        case (state)
          ST_RDW: begin
            rdata_q <= ram_rdata;
            coll_q  <= 1'b0;
          end
          ST_WR: begin
            rdata_q <= old_q;
            coll_q  <= |(old_q & cpu_wdata);
          end
          default: begin
            coll_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cpu_ack       = (state == ST_ACK) && !rst;
  assign cpu_rdata     = rdata_q;
  assign cpu_collision = coll_q;
  assign vga_rdata     = ram_rdata;
  assign vga_rvalid    = rvalid_q;
  assign ready         = !init_busy;

endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;
  import chip8_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vga_req = 1'b0;
  logic [7:0] vga_addr = '0;
  logic [7:0] vga_rdata;
  logic       vga_rvalid;
  logic       cpu_req = 1'b0;
  logic [1:0] cpu_op = '0;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       cpu_collision;
  logic       ready;

  fb_arbiter #(.CLEAR_ON_RESET(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .vga_rdata     (vga_rdata),
    .vga_rvalid    (vga_rvalid),
    .cpu_req       (cpu_req),
    .cpu_op        (cpu_op),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_ack       (cpu_ack),
    .cpu_rdata     (cpu_rdata),
    .cpu_collision (cpu_collision),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mdl [256];
  logic [7:0] vq [$];

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         lat;
    logic [7:0] rdata;
    logic       coll;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // VGA scoreboard: rvalid must trail vga_req by one cycle, and each valid
  // beat pops the byte that was expected when the request was driven.
  initial begin
    logic last_req;
    logic last_rst;
    logic [7:0] e;
    last_req = 1'b0;
    last_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && !last_rst) begin
        check("vga_rvalid_delay", vga_rvalid, last_req);
        if (vga_rvalid) begin
          if (vq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL vga_sb_underflow: got rvalid with empty queue at %0t", $time);
          end else begin
            e = vq.pop_front();
            check("vga_rdata", vga_rdata, e);
          end
        end
      end
      last_req = vga_req;
      last_rst = rst;
    end
  end

  function automatic logic want_vga(input int vmode, input int n);
    case (vmode)
      1: return (n >= 2) && (n <= 6);
      2: return (n >= 8) && (n % 8 == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_vga(input logic on, input logic [7:0] a, input logic [7:0] exp);
    if (on) begin
      vga_req  = 1'b1;
      vga_addr = a;
      vq.push_back(exp);
    end else begin
      vga_req = 1'b0;
    end
  endtask

  // One CPU transaction; latency counted in edges after the request is driven.
  task automatic run_op(input logic [1:0] op, input logic [7:0] addr,
                        input logic [7:0] wdata, input int vmode,
                        input logic [7:0] vaddr, input logic [7:0] vexp,
                        output int lat, output logic [7:0] rd, output logic co);
    int n;
    n = 0;
    cpu_req   = 1'b1;
    cpu_op    = op;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    drive_vga(want_vga(vmode, 0), vaddr, vexp);
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (cpu_ack) break;
      drive_vga(want_vga(vmode, n), vaddr, vexp);
    end
    lat = n;
    rd  = cpu_rdata;
    co  = cpu_collision;
    cpu_req = 1'b0;
    vga_req = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", cpu_ack, 0);
    check("rdata_hold", cpu_rdata, rd);
    check("coll_hold", cpu_collision, co);
  endtask

  task automatic vga_sweep();
    for (int i = 0; i < 256; i++) begin
      drive_vga(1'b1, 8'(i), mdl[i]);
      @(posedge clk); #1;
    end
    vga_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("vga_sb_drained", vq.size(), 0);
  endtask

  task automatic do_check_op(input string name, input logic [1:0] op,
                             input logic [7:0] addr, input logic [7:0] wdata,
                             input int vmode, input logic [7:0] vexp,
                             input int elat, input logic [7:0] erd, input logic eco);
    int lat;
    logic [7:0] rd;
    logic co;
    run_op(op, addr, wdata, vmode, addr, vexp, lat, rd, co);
    check({name, "_latency"}, lat, elat);
    check({name, "_rdata"}, rd, erd);
    check({name, "_collision"}, co, eco);
    if (op == OP_DRAW) mdl[addr] = mdl[addr] ^ wdata;
  endtask

  initial begin
    int m;
    int acks;
    int exp_lat;
    int w;
    int lat;
    logic [7:0] rd;
    logic co;

    tbl[0]  = '{2'b00, 8'h10, 8'hF0, 3, 8'h00, 1'b0};
    tbl[1]  = '{2'b00, 8'h10, 8'hF0, 3, 8'hF0, 1'b1};
    tbl[2]  = '{2'b10, 8'h10, 8'h00, 2, 8'h00, 1'b0};
    tbl[3]  = '{2'b00, 8'h3F, 8'hA5, 3, 8'h00, 1'b0};
    tbl[4]  = '{2'b10, 8'h3F, 8'h00, 2, 8'hA5, 1'b0};
    tbl[5]  = '{2'b11, 8'h3F, 8'h00, 2, 8'hA5, 1'b0};
    tbl[6]  = '{2'b00, 8'h3F, 8'h0F, 3, 8'hA5, 1'b1};
    tbl[7]  = '{2'b10, 8'h3F, 8'h00, 2, 8'hAA, 1'b0};
    tbl[8]  = '{2'b00, 8'hFF, 8'h80, 3, 8'h00, 1'b0};
    tbl[9]  = '{2'b00, 8'h00, 8'h01, 3, 8'h00, 1'b0};
    tbl[10] = '{2'b10, 8'hFF, 8'h00, 2, 8'h80, 1'b0};

    // Reset values and the automatic clear.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", cpu_ack, 0);
    check("rst_collision", cpu_collision, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_rvalid", vga_rvalid, 0);
    check("rst_ready", ready, 0);
    rst = 1'b0;
    m = 0;
    acks = 0;
    while (!ready && m < 1000) begin
      @(posedge clk); #1;
      m++;
      if (cpu_ack) acks++;
    end
    check("init_ready_latency", m, 257);
    check("init_no_ack", acks, 0);
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    vga_sweep();

    // Table-driven uncontended operations.
    for (int i = 0; i < 11; i++) begin
      do_check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wdata,
                  0, 8'h00, tbl[i].lat, tbl[i].rdata, tbl[i].coll);
    end
    vga_sweep();

    // VGA burst covering the write phase: write slips 5 cycles, VGA sees pre-draw byte.
    do_check_op("burst_draw", 2'b00, 8'h20, 8'h3C, 1, mdl[8'h20], 8, 8'h00, 1'b0);
    do_check_op("burst_read", 2'b10, 8'h20, 8'h00, 0, 8'h00, 2, 8'h3C, 1'b0);
    do_check_op("redraw", 2'b00, 8'h20, 8'h3C, 0, 8'h00, 3, 8'h3C, 1'b1);

    // Clear-all with VGA stealing every 8th cycle.
    w = 0;
    exp_lat = 0;
    while (w < 256) begin
      exp_lat++;
      if (exp_lat % 8 != 0) w++;
    end
    exp_lat = exp_lat + 1;
    run_op(2'b01, 8'h77, 8'h00, 2, 8'h00, 8'h00, lat, rd, co);
    check("clear_latency", lat, exp_lat);
    check("clear_collision", co, 0);
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    vga_sweep();

    // Reset during a clear at counter 100.
    do_check_op("dirty_a", 2'b00, 8'h05, 8'hFF, 0, 8'h00, 3, 8'h00, 1'b0);
    do_check_op("dirty_b", 2'b00, 8'hC8, 8'h11, 0, 8'h00, 3, 8'h00, 1'b0);
    do_check_op("dirty_c", 2'b00, 8'h05, 8'hFF, 0, 8'h00, 3, 8'hFF, 1'b1);
    do_check_op("dirty_d", 2'b00, 8'h05, 8'h5A, 0, 8'h00, 3, 8'h00, 1'b0);
    cpu_req = 1'b1;
    cpu_op  = 2'b01;
    acks = 0;
    for (int n = 1; n <= 101; n++) begin
      @(posedge clk); #1;
      if (cpu_ack) acks++;
    end
    rst = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check("abort_ack", cpu_ack, 0);
    check("abort_rdata", cpu_rdata, 0);
    check("abort_collision", cpu_collision, 0);
    check("abort_ready", ready, 0);
    rst = 1'b0;
    m = 0;
    while (!ready && m < 1000) begin
      @(posedge clk); #1;
      m++;
      if (cpu_ack) acks++;
    end
    check("restart_ready_latency", m, 257);
    check("abort_no_ack", acks, 0);
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    do_check_op("post_a", 2'b10, 8'h05, 8'h00, 0, 8'h00, 2, 8'h00, 1'b0);
    do_check_op("post_b", 2'b10, 8'hC8, 8'h00, 0, 8'h00, 2, 8'h00, 1'b0);
    vga_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
